// File: rtl/muldiv_arbiter.sv
// Two-lane arbiter in front of one shared multi-cycle HI/LO unit (MULT/MULTU/DIV/DIVU).
// Optional build macro MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| finish in one cycle.
module muldiv_arbiter #(
    parameter int DATA_W      = 32,
    parameter int MUL_LATENCY = 3,
    parameter int TAG_W       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flash,
    input  logic [1:0]             req_valid,
    input  logic [1:0][1:0]        req_op,
    input  logic [1:0][DATA_W-1:0] req_num1,
    input  logic [1:0][DATA_W-1:0] req_num2,
    input  logic [1:0][TAG_W-1:0]  req_tag,
    output logic [1:0]             grant,
    output logic                   busy,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_W-1:0]      resp_hi,
    output logic [DATA_W-1:0]      resp_lo,
    output logic [TAG_W-1:0]       resp_tag,
    output logic                   resp_lane
);
    localparam int CNT_MAX = (DATA_W > MUL_LATENCY) ? DATA_W : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_LATENCY >= 2) ? MUL_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] op_a, op_b;
    logic              op_signed;
    logic [DATA_W-1:0] div_rem, div_quo, div_dvs;
    logic              q_neg, r_neg;

    logic              idle, accept, sel;
    logic [1:0]        sel_op;
    logic [DATA_W-1:0] sel_a, sel_b, a_mag, b_mag;
    logic [TAG_W-1:0]  sel_tag;
    logic              sel_signed, a_neg, b_neg, div_zero, early;

    assign idle     = (state == S_IDLE);
    assign grant[0] = req_valid[0] & idle & ~flash;
    assign grant[1] = req_valid[1] & ~req_valid[0] & idle & ~flash;
    assign accept   = |grant;
    assign sel      = grant[1];
    assign busy     = ~idle;
    assign resp_valid = (state == S_DONE);

    assign sel_op     = req_op[sel];
    assign sel_a      = req_num1[sel];
    assign sel_b      = req_num2[sel];
    assign sel_tag    = req_tag[sel];
    assign sel_signed = ~sel_op[0];
    assign a_neg      = sel_signed & sel_a[DATA_W-1];
    assign b_neg      = sel_signed & sel_b[DATA_W-1];
    assign a_mag      = a_neg ? -sel_a : sel_a;
    assign b_mag      = b_neg ? -sel_b : sel_b;
    assign div_zero   = (sel_b == '0);
`ifdef MULDIV_EARLY_OUT_EN
    assign early = (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // In IDLE the multiplier sees the live request so a 1-cycle latency build can finish at accept.
    logic [DATA_W-1:0]   mul_a, mul_b;
    logic                mul_signed;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;
    assign mul_a      = idle ? sel_a : op_a;
    assign mul_b      = idle ? sel_b : op_b;
    assign mul_signed = idle ? sel_signed : op_signed;
    assign ext_a      = {{DATA_W{mul_signed & mul_a[DATA_W-1]}}, mul_a};
    assign ext_b      = {{DATA_W{mul_signed & mul_b[DATA_W-1]}}, mul_b};
    assign prod       = ext_a * ext_b;

    logic [DATA_W:0]   rem_shift, trial;
    logic [DATA_W-1:0] step_rem, step_quo, fix_rem, fix_quo;
    logic              take;
    assign rem_shift = {div_rem, div_quo[DATA_W-1]};
    assign trial     = rem_shift - {1'b0, div_dvs};
    assign take      = ~trial[DATA_W];
    assign step_rem  = take ? trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    assign step_quo  = {div_quo[DATA_W-2:0], take};
    assign fix_quo   = q_neg ? -step_quo : step_quo;
    assign fix_rem   = r_neg ? -step_rem : step_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) begin
                if (sel_op[1]) state_nxt = (div_zero || early) ? S_DONE : S_DIV;
                else           state_nxt = (MUL_LATENCY <= 1) ? S_DONE : S_MUL;
            end
            S_MUL:  if (cnt == '0) state_nxt = S_DONE;
            S_DIV:  if (cnt == '0) state_nxt = S_DONE;
            S_DONE: if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flash) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0; op_a <= '0; op_b <= '0; op_signed <= 1'b0;
            div_rem <= '0; div_quo <= '0; div_dvs <= '0; q_neg <= 1'b0; r_neg <= 1'b0;
            resp_hi <= '0; resp_lo <= '0; resp_tag <= '0; resp_lane <= 1'b0;
        end else if (flash) begin
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_a      <= sel_a;
                    op_b      <= sel_b;
                    op_signed <= sel_signed;
                    resp_tag  <= sel_tag;
                    resp_lane <= sel;
                    div_rem   <= '0;
                    div_quo   <= a_mag;
                    div_dvs   <= b_mag;
                    q_neg     <= a_neg ^ b_neg;
                    r_neg     <= a_neg;
                    cnt       <= sel_op[1] ? DIV_LOAD : MUL_LOAD;
                    if (sel_op[1] && div_zero) begin
                        resp_lo <= '1;
                        resp_hi <= sel_a;
                    end else if (sel_op[1] && early) begin
                        resp_lo <= '0;
                        resp_hi <= sel_a;
                    end else if (!sel_op[1] && MUL_LATENCY <= 1) begin
                        {resp_hi, resp_lo} <= prod;
                    end
                end
                S_MUL: begin
                    if (cnt == '0) {resp_hi, resp_lo} <= prod;
                    else           cnt <= cnt - 1'b1;
                end
                S_DIV: begin
                    // Last shift/subtract step and sign fixup share the edge into DONE.
                    div_rem <= step_rem;
                    div_quo <= step_quo;
                    if (cnt == '0) begin
                        resp_hi <= fix_rem;
                        resp_lo <= fix_quo;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_arbiter.sv
// Self-checking bench for muldiv_arbiter: directed table, flush/reset sequences, randomized ops vs model.
module tb_muldiv_arbiter;
    localparam int W  = 32;
    localparam int L  = 3;
    localparam int TW = 5;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = W + 1;
`endif

    logic clk = 1'b0;
    logic rst, flash, resp_ready;
    logic [1:0] req_valid;
    logic [1:0][1:0] req_op;
    logic [1:0][W-1:0] req_num1, req_num2;
    logic [1:0][TW-1:0] req_tag;
    logic [1:0] grant;
    logic busy, resp_valid, resp_lane;
    logic [W-1:0] resp_hi, resp_lo;
    logic [TW-1:0] resp_tag;

    muldiv_arbiter #(.DATA_W(W), .MUL_LATENCY(L), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flash(flash), .req_valid(req_valid), .req_op(req_op),
        .req_num1(req_num1), .req_num2(req_num2), .req_tag(req_tag), .grant(grant),
        .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hi(resp_hi),
        .resp_lo(resp_lo), .resp_tag(resp_tag), .resp_lane(resp_lane)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   valid;
        logic [1:0]   op0, op1;
        logic [W-1:0] a0, b0, a1, b1;
        logic [TW-1:0] tag0, tag1;
        logic [1:0]   exp_grant;
        logic [W-1:0] exp_hi, exp_lo;
        logic [TW-1:0] exp_tag;
        logic         exp_lane;
        int           exp_lat;
        int           hold;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: results straight from arithmetic on 64-bit values.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo, output int lat);
        longint sa, sb, q, r, ma, mb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[1]) begin
            lat = L;
            if (op == 2'b00) p = 64'(sa * sb);
            else             p = {32'b0, a} * {32'b0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 0) begin
            lat = 1;
            lo  = '1;
            hi  = a;
        end else if (op[0]) begin
            lo  = a / b;
            hi  = a % b;
            lat = (a < b) ? EO_LAT : W + 1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            lat = (ma < mb) ? EO_LAT : W + 1;
        end
    endfunction

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] op0, input logic [W-1:0] a0,
                                input logic [W-1:0] b0, input logic [TW-1:0] tag0, input logic [1:0] op1,
                                input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [TW-1:0] tag1,
                                input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input int exp_lat,
                                input int hold);
        vec_t v;
        v.valid = valid; v.op0 = op0; v.a0 = a0; v.b0 = b0; v.tag0 = tag0;
        v.op1 = op1; v.a1 = a1; v.b1 = b1; v.tag1 = tag1;
        v.exp_grant = valid[0] ? 2'b01 : 2'b10;
        v.exp_lane  = ~valid[0];
        v.exp_tag   = valid[0] ? tag0 : tag1;
        v.exp_hi = exp_hi; v.exp_lo = exp_lo; v.exp_lat = exp_lat; v.hold = hold;
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string nm);
        int k;
        logic busy_grant;
        logic unstable;
        @(negedge clk);
        req_valid = v.valid;
        req_op[0] = v.op0; req_num1[0] = v.a0; req_num2[0] = v.b0; req_tag[0] = v.tag0;
        req_op[1] = v.op1; req_num1[1] = v.a1; req_num2[1] = v.b1; req_tag[1] = v.tag1;
        resp_ready = 1'b0;
        #1 check({nm, " grant"}, 64'(grant), 64'(v.exp_grant));
        @(posedge clk);
        busy_grant = 1'b0;
        k = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            k = n;
            req_valid = 2'b11;
            if (grant != 2'b00) busy_grant = 1'b1;
            if (resp_valid) break;
        end
        check({nm, " latency"}, 64'(k), 64'(v.exp_lat));
        check({nm, " grant_while_busy"}, 64'(busy_grant), 64'(0));
        check({nm, " hi"}, 64'(resp_hi), 64'(v.exp_hi));
        check({nm, " lo"}, 64'(resp_lo), 64'(v.exp_lo));
        check({nm, " tag_lane"}, 64'({resp_tag, resp_lane}), 64'({v.exp_tag, v.exp_lane}));
        if (v.hold > 0) begin
            unstable = 1'b0;
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                if (!resp_valid || grant != 2'b00 || resp_hi != v.exp_hi || resp_lo != v.exp_lo ||
                    resp_tag != v.exp_tag || resp_lane != v.exp_lane) unstable = 1'b1;
            end
            check({nm, " hold_stable"}, 64'(unstable), 64'(0));
        end
        resp_ready = 1'b1;
        #1 check({nm, " no_grant_in_done"}, 64'(grant), 64'(0));
        @(negedge clk);
        check({nm, " release"}, 64'({busy, resp_valid}), 64'(0));
        check({nm, " regrant"}, 64'(grant), 64'(2'b01));
        resp_ready = 1'b0;
        req_valid  = 2'b00;
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        rst = 1'b1; flash = 1'b0; resp_ready = 1'b0; req_valid = 2'b00;
        req_op = '0; req_num1 = '0; req_num2 = '0; req_tag = '0;

        tbl[0] = mk(2'b11, 2'b01, 32'hFFFF_FFFF, 32'd2, 5'd3, 2'b10, 32'd5, 32'd1, 5'd4,
                    32'h1, 32'hFFFF_FFFE, L, 0);
        tbl[1] = mk(2'b10, 2'b00, 32'd1, 32'd1, 5'd0, 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd9,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 1, 1);
        tbl[2] = mk(2'b01, 2'b11, 32'd100, 32'd0, 5'd1, 2'b00, 32'd0, 32'd0, 5'd0,
                    32'd100, 32'hFFFF_FFFF, 1, 2);
        tbl[3] = mk(2'b10, 2'b00, 32'd0, 32'd0, 5'd0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17,
                    32'h0, 32'h8000_0000, W + 1, 0);
        tbl[4] = mk(2'b01, 2'b11, 32'd3, 32'd10, 5'd2, 2'b00, 32'd0, 32'd0, 5'd0,
                    32'd3, 32'd0, EO_LAT, 0);
        tbl[5] = mk(2'b11, 2'b00, 32'hFFFF_FFFD, 32'd5, 5'd6, 2'b01, 32'd7, 32'd7, 5'd7,
                    32'hFFFF_FFFF, 32'hFFFF_FFF1, L, 5);
        tbl[6] = mk(2'b10, 2'b00, 32'd0, 32'd0, 5'd0, 2'b11, 32'hFFFF_FFFF, 32'h10, 5'd31,
                    32'hF, 32'h0FFF_FFFF, W + 1, 0);
        tbl[7] = mk(2'b01, 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd0, 2'b00, 32'd0, 32'd0, 5'd0,
                    32'd1, 32'hFFFF_FFFD, W + 1, 0);
        tbl[8] = mk(2'b11, 2'b10, 32'hFFFF_FFF8, 32'd3, 5'd12, 2'b11, 32'd9, 32'd3, 5'd13,
                    32'hFFFF_FFFE, 32'hFFFF_FFFE, W + 1, 0);
        tbl[9] = mk(2'b10, 2'b00, 32'd0, 32'd0, 5'd0, 2'b10, 32'hFFFF_FFFD, 32'd10, 5'd21,
                    32'hFFFF_FFFD, 32'd0, EO_LAT, 1);

        #2;
        check("reset_state", 64'({grant, busy, resp_valid, resp_lane}), 64'(0));
        check("reset_data", {resp_hi, resp_lo}, 64'(0));
        check("reset_tag", 64'(resp_tag), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Flush mid-divide: no response, idle on the next cycle, lane 0 grantable again.
        begin
            int k;
            logic rose;
            @(negedge clk);
            req_valid = 2'b01; req_op[0] = 2'b10; req_num1[0] = 32'd1000; req_num2[0] = 32'd7;
            req_tag[0] = 5'd5;
            #1 check("flash grant", 64'(grant), 64'(2'b01));
            @(posedge clk);
            rose = 1'b0;
            for (k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (resp_valid) rose = 1'b1;
            end
            flash = 1'b1;
            #1 check("flash no_grant", 64'(grant), 64'(0));
            @(negedge clk);
            flash = 1'b0;
            if (resp_valid) rose = 1'b1;
            check("flash idle", 64'({busy, resp_valid}), 64'(0));
            #1 check("flash regrant", 64'(grant), 64'(2'b01));
            req_valid = 2'b00;
            for (k = 0; k < 40; k++) begin
                @(negedge clk);
                if (resp_valid) rose = 1'b1;
            end
            check("flash no_resp", 64'(rose), 64'(0));
        end

        // Asynchronous reset in the middle of a divide.
        begin
            @(negedge clk);
            req_valid = 2'b10; req_op[1] = 2'b11; req_num1[1] = 32'd12345; req_num2[1] = 32'd3;
            req_tag[1] = 5'd11;
            @(posedge clk);
            repeat (5) @(negedge clk);
            req_valid = 2'b00;
            rst = 1'b1;
            #1 check("rst_mid busy", 64'({busy, resp_valid, resp_lane}), 64'(0));
            check("rst_mid data", {resp_hi, resp_lo}, 64'(0));
            check("rst_mid tag", 64'(resp_tag), 64'(0));
            @(negedge clk);
            rst = 1'b0;
        end

        for (int i = 0; i < 16; i++) begin
            logic [1:0] valid, op0, op1, sop;
            logic [W-1:0] a0, b0, a1, b1, sa, sb, hi, lo;
            int lat, mode;
            valid = 2'($urandom_range(1, 3));
            op0 = 2'($urandom); op1 = 2'($urandom);
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            mode = $urandom_range(0, 3);
            if (mode == 1) begin a0 = 32'($urandom_range(0, 15)); a1 = 32'($urandom_range(0, 15)); end
            if (mode == 2) begin b0 = 32'($urandom_range(0, 3));  b1 = 32'($urandom_range(0, 3)); end
            if (mode == 3) begin b0 = 32'($urandom_range(1, 255)); b1 = -32'($urandom_range(1, 255)); end
            sop = valid[0] ? op0 : op1;
            sa  = valid[0] ? a0 : a1;
            sb  = valid[0] ? b0 : b1;
            model(sop, sa, sb, hi, lo, lat);
            rv = mk(valid, op0, a0, b0, 5'($urandom), op1, a1, b1, 5'($urandom), hi, lo, lat,
                    $urandom_range(0, 3));
            run_op(rv, $sformatf("rnd%0d", i));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
